// File: rtl/pwm_sched_pkg.sv
// Shared encodings and default sizing for the class-D PWM duty scheduler.
// Build option: SOFT_START_EN enables the start-up duty ramp.
package pwm_sched_pkg;

    localparam int CNT_W_DEF     = 5;
    localparam int DUTY_DEF      = 14;
    localparam int START_DLY_DEF = 4;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_START = 2'd1,
        S_RAMP  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter with synchronous clear.
// Build option: none.
module pwm_period_counter
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_central,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] contador,
    output logic             wrap,
    output logic             period_start
);

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central)
            contador <= '0;
        else if (clr || !en)
            contador <= '0;
        else
            contador <= contador + 1'b1;
    end

    assign wrap         = en && !clr && (contador == '1);
    assign period_start = en && (contador == '0);

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Class-D PWM controller: duty arbitration, start-up sequencing, output.
// Build option: SOFT_START_EN adds the RAMP state between START and RUN.
module pwm_duty_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_DUTY = DUTY_DEF,
    parameter int START_DLY    = START_DLY_DEF
) (
    input  logic             clk,
    input  logic             reset_central,
    input  logic             enable,
    input  logic             req_a,
    input  logic [CNT_W-1:0] duty_a,
    input  logic             req_b,
    input  logic [CNT_W-1:0] duty_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [CNT_W-1:0] contador,
    output logic [CNT_W-1:0] pwm_ref,
    output logic             pwm_out,
    output logic             period_start,
    output logic [1:0]       state
);

    localparam int SC_W = $clog2(START_DLY + 1);

    state_t            st_q, st_nxt;
    logic [CNT_W-1:0]  ref_nxt;
    logic [CNT_W-1:0]  tgt_q;
    logic              pend_q;
    logic [SC_W-1:0]   sc_q, sc_nxt;
    logic              run;
    logic              wrap;
    logic              acc_ok, acc_a, acc_b;

    assign run   = (st_q != S_OFF);
    assign state = st_q;

    pwm_period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk           (clk),
        .reset_central (reset_central),
        .en            (run),
        .clr           (!enable),
        .contador      (contador),
        .wrap          (wrap),
        .period_start  (period_start)
    );

    // B wins ties; a pending update blocks both until the next wrap.
    assign acc_ok = run && enable && !pend_q;
    assign acc_b  = acc_ok && req_b;
    assign acc_a  = acc_ok && req_a && !req_b;

`ifdef SOFT_START_EN
    logic [CNT_W-1:0] ref_step;

    always_comb begin
        ref_step = pwm_ref;
        if (pwm_ref < tgt_q)
            ref_step = pwm_ref + 1'b1;
        else if (pwm_ref > tgt_q)
            ref_step = pwm_ref - 1'b1;
    end
`endif

    always_comb begin
        st_nxt  = st_q;
        ref_nxt = pwm_ref;
        sc_nxt  = sc_q;
        if (!enable) begin
            st_nxt  = S_OFF;
            ref_nxt = '0;
            sc_nxt  = '0;
        end else begin
            unique case (st_q)
                S_OFF: begin
                    st_nxt = S_START;
                end
                S_START: begin
                    ref_nxt = '0;
                    if (wrap) begin
                        if (sc_q == SC_W'(START_DLY - 1)) begin
                            sc_nxt = '0;
`ifdef SOFT_START_EN
                            ref_nxt = ref_step;
                            st_nxt  = (ref_step == tgt_q) ? S_RUN
                                                          : S_RAMP;
`else
                            ref_nxt = tgt_q;
                            st_nxt  = S_RUN;
`endif
                        end else begin
                            sc_nxt = sc_q + 1'b1;
                        end
                    end
                end
`ifdef SOFT_START_EN
                S_RAMP: begin
                    if (wrap) begin
                        ref_nxt = ref_step;
                        if (ref_step == tgt_q)
                            st_nxt = S_RUN;
                    end
                end
`endif
                S_RUN: begin
                    if (wrap)
                        ref_nxt = tgt_q;
                end
                default: begin
                    st_nxt = S_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_central) begin
        if (reset_central) begin
            st_q    <= S_OFF;
            pwm_ref <= '0;
            sc_q    <= '0;
            tgt_q   <= CNT_W'(DEFAULT_DUTY);
            pend_q  <= 1'b0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            st_q    <= st_nxt;
            pwm_ref <= ref_nxt;
            sc_q    <= sc_nxt;
            ack_a   <= acc_a;
            ack_b   <= acc_b;
            pwm_out <= run && enable && (contador < pwm_ref);
            unique case (1'b1)
                acc_b:   tgt_q <= duty_b;
                acc_a:   tgt_q <= duty_a;
                default: tgt_q <= tgt_q;
            endcase
            // An accept on the wrap cycle keeps pending for the next wrap.
            if (!enable)
                pend_q <= 1'b0;
            else if (acc_a || acc_b)
                pend_q <= 1'b1;
            else if (wrap)
                pend_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler (either SOFT_START_EN build).
module tb_pwm_duty_scheduler;

    logic       clk;
    logic       reset_central;
    logic       enable;
    logic       req_a, req_b;
    logic [4:0] duty_a, duty_b;
    logic       ack_a, ack_b;
    logic [4:0] contador, pwm_ref;
    logic       pwm_out, period_start;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int na = 0;
    int nb = 0;

    pwm_duty_scheduler dut (
        .clk           (clk),
        .reset_central (reset_central),
        .enable        (enable),
        .req_a         (req_a),
        .duty_a        (duty_a),
        .req_b         (req_b),
        .duty_b        (duty_b),
        .ack_a         (ack_a),
        .ack_b         (ack_b),
        .contador      (contador),
        .pwm_ref       (pwm_ref),
        .pwm_out       (pwm_out),
        .period_start  (period_start),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_a) na++;
        if (ack_b) nb++;
    end

    task automatic chk_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cnt(input int tgt);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (contador != 5'(tgt) && n < 40);
        chk_eq("reach_cnt", contador, tgt);
    endtask

    task automatic count_high(input string tag, input int exp);
        int hi;
        hi = 0;
        repeat (32) begin
            tick();
            hi += pwm_out;
        end
        chk_eq(tag, hi, exp);
    endtask

    task automatic startup(input int last);
        int mx;
        enable = 1'b1;
        tick();
        chk_eq("start_state", state, 1);
        chk_eq("start_pstart", period_start, 1);
        chk_eq("start_cnt", contador, 0);
        mx = 0;
        repeat (127) begin
            tick();
            if (pwm_ref > mx) mx = pwm_ref;
        end
        chk_eq("start_ref0", mx, 0);
        chk_eq("start_end_cnt", contador, 31);
        chk_eq("start_end_state", state, 1);
        tick();
        chk_eq("dly_wrap_cnt", contador, 0);
`ifdef SOFT_START_EN
        chk_eq("ramp_first", pwm_ref, 1);
        chk_eq("ramp_state", state, 2);
        for (int k = 2; k <= last; k++) begin
            repeat (32) tick();
            chk_eq("ramp_step", pwm_ref, k);
        end
        chk_eq("ramp_end_state", state, (last == 14) ? 3 : 2);
`else
        chk_eq("jump_ref", pwm_ref, 14);
        chk_eq("jump_state", state, 3);
`endif
    endtask

    initial begin
        int n0, lowpos, hi;
        reset_central = 1'b1;
        enable = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        duty_a = '0;
        duty_b = '0;
        repeat (2) tick();
        chk_eq("rst_cnt", contador, 0);
        chk_eq("rst_ref", pwm_ref, 0);
        chk_eq("rst_out", pwm_out, 0);
        chk_eq("rst_state", state, 0);
        chk_eq("rst_pstart", period_start, 0);
        chk_eq("rst_acks", ack_a + ack_b, 0);
        reset_central = 1'b0;
        tick();
        chk_eq("off_hold_state", state, 0);

        // Startup interrupted at pwm_ref 7 (RAMP) or in RUN
        startup(7);
        n0 = na + nb;
        enable = 1'b0;
        req_b = 1'b1;
        duty_b = 5'd9;
        tick();
        chk_eq("dis_state", state, 0);
        chk_eq("dis_cnt", contador, 0);
        chk_eq("dis_ref", pwm_ref, 0);
        chk_eq("dis_out", pwm_out, 0);
        repeat (5) tick();
        chk_eq("off_no_ack", na + nb - n0, 0);
        chk_eq("off_cnt", contador, 0);
        req_b = 1'b0;

        // Re-enable: full START delay again, then up to 14
        startup(14);
        count_high("run_high14", 14);

        // Simultaneous requests: B first, A after the next wrap
        req_a = 1'b1;
        duty_a = 5'd5;
        req_b = 1'b1;
        duty_b = 5'd20;
        tick();
        chk_eq("arb_ack_b", ack_b, 1);
        chk_eq("arb_no_ack_a", ack_a, 0);
        req_b = 1'b0;
        n0 = na;
        to_cnt(0);
        chk_eq("arb_a_waits", na - n0, 0);
        chk_eq("arb_ref20", pwm_ref, 20);
        tick();
        chk_eq("arb_ack_a", ack_a, 1);
        req_a = 1'b0;
        tick();
        chk_eq("arb_ack_a_pulse", ack_a, 0);
        chk_eq("arb_ref_hold", pwm_ref, 20);
        to_cnt(0);
        chk_eq("arb_ref5", pwm_ref, 5);

        // Duty 0
        req_b = 1'b1;
        duty_b = 5'd0;
        tick();
        chk_eq("d0_ack", ack_b, 1);
        req_b = 1'b0;
        to_cnt(0);
        chk_eq("d0_ref", pwm_ref, 0);
        count_high("d0_high", 0);

        // Duty 31: low only for the contador==31 slot
        req_b = 1'b1;
        duty_b = 5'd31;
        tick();
        chk_eq("d31_ack", ack_b, 1);
        req_b = 1'b0;
        to_cnt(0);
        chk_eq("d31_ref", pwm_ref, 31);
        hi = 0;
        lowpos = -1;
        repeat (32) begin
            tick();
            hi += pwm_out;
            if (!pwm_out) lowpos = contador;
        end
        chk_eq("d31_high", hi, 31);
        chk_eq("d31_low_pos", lowpos, 0);

        // Asynchronous reset mid-period
        to_cnt(17);
        #1 reset_central = 1'b1;
        #1;
        chk_eq("arst_cnt", contador, 0);
        chk_eq("arst_ref", pwm_ref, 0);
        chk_eq("arst_state", state, 0);
        chk_eq("arst_out", pwm_out, 0);
        chk_eq("arst_pstart", period_start, 0);
        tick();
        reset_central = 1'b0;
        startup(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pwm_duty_scheduler.md
Name: pwm_duty_scheduler

Overview:
Controller for the audio class-D PWM stage. It owns the free-running period counter (`contador`) and the active duty reference (`pwm_ref`), and generates the PWM output. It arbitrates duty-update requests from two sources:
- A: audio/tone path.
- B: volume/mute control.

Duty changes are applied only at period boundaries, so the output is glitch-free. After enable it sequences a startup delay and an optional soft-start ramp, replacing the fixed-threshold reference logic.

Parameters:
CNT_W, 5, width of period counter and duty values (period = 2^CNT_W clk cycles)
DEFAULT_DUTY, 14, duty target loaded at reset (5'b01110)
START_DLY, 4, full periods spent in START with duty 0 before ramp/run

Ports:
clk  in  1  system clock
reset_central  in  1  asynchronous, active-high reset
enable  in  1  run PWM; 0 forces OFF
req_a  in  1  duty update request, source A (level, held until ack_a)
duty_a  in  CNT_W  requested duty, source A
req_b  in  1  duty update request, source B (level, held until ack_b)
duty_b  in  CNT_W  requested duty, source B
ack_a  out  1  one-cycle accept pulse, source A
ack_b  out  1  one-cycle accept pulse, source B
contador  out  CNT_W  period counter
pwm_ref  out  CNT_W  active duty
pwm_out  out  1  PWM output
period_start  out  1  one-cycle pulse when contador==0 in a non-OFF state
state  out  2  OFF=0, START=1, RAMP=2, RUN=3

Behaviour:
- Reset is `reset_central`, asynchronous, active-high; clock is `clk`.
- Reset values:
  - contador=0, pwm_ref=0, pwm_out=0, ack_a=ack_b=0, period_start=0, state=OFF.
  - target=DEFAULT_DUTY, pending=0, start counter=0.
  - Reset mid-operation aborts immediately; no partial period completes.
- Counter:
  - Increments every cycle in START/RAMP/RUN.
  - Wraps from 2^CNT_W-1 to 0. "wrap" = the cycle in which contador==2^CNT_W-1 while incrementing.
  - In OFF it is held at 0.
- pwm_out:
  - Registered: pwm_out <= (state!=OFF) && (contador < pwm_ref), i.e. 1-cycle latency.
  - duty 0 gives constant 0; duty 2^CNT_W-1 gives high for 31 of 32 cycles.
- Requests:
  - A request is accepted when state!=OFF and pending=0.
  - B has priority if both are asserted in the same cycle.
  - Accept writes target <= duty_x and sets pending=1. ack_x pulses the cycle after acceptance.
  - The loser, or any request seen while pending=1, waits with no ack.
  - The same req held high is accepted at most once per ack; the requester must drop req after ack.
- pending is cleared at every wrap; at that wrap the FSM consumes target as below.
- FSM transitions:
  - OFF -> START when enable=1.
  - Any state -> OFF on the next cycle when enable=0: contador=0, pwm_ref=0, pending=0, target retained.
  - START: pwm_ref=0. After START_DLY wraps -> RAMP (if SOFT_START_EN) else RUN with pwm_ref<=target at that wrap.
  - RAMP: at each wrap pwm_ref steps ±1 toward target. When pwm_ref==target after the step -> RUN.
  - RUN: at each wrap pwm_ref <= target.
- Simultaneous wrap and accept: the accept is taken. The value applies at the next wrap, not the current one.

Optional Feature:
SOFT_START_EN:
- Defined: RAMP state exists as above, limiting audible pop at start-up.
- Undefined: RAMP is never entered. START goes directly to RUN with pwm_ref<=target at the START_DLY-th wrap. The state encoding is unchanged, with 2 unused.

Decomposition:
- Package `pwm_sched_pkg`: state encoding constants (OFF/START/RAMP/RUN), default CNT_W, DEFAULT_DUTY, START_DLY.
- One natural sub-module, `pwm_period_counter`: enable-gated counter with sync clear, outputting contador, wrap and period_start.
- Arbitration, FSM and duty registers stay in the top level.

Test Plan:
1. Reset low, enable=1, SOFT_START_EN defined, no requests:
   - pwm_ref=0 for 128 cycles.
   - Then pwm_ref = 1, 2, …, 14 at successive wraps; state=RUN.
   - pwm_out high for exactly 14 of 32 cycles per period.
2. In RUN, req_a=1/duty_a=5 and req_b=1/duty_b=20 in the same cycle:
   - ack_b pulses the next cycle; pwm_ref=20 from the next contador=0.
   - ack_a pulses after that wrap; pwm_ref=5 one period later.
3. Duty boundaries via req_b:
   - duty 0 -> pwm_out constantly 0.
   - duty 31 -> pwm_out low only at contador=31, with 1-cycle latency.
4. Deassert enable during RAMP at pwm_ref=7:
   - The next cycle shows state=OFF, contador=0, pwm_ref=0, pwm_out=0; no acks while OFF.
   - Re-enable repeats the START delay.
5. Assert reset_central mid-RUN at contador=17 (asynchronous):
   - All outputs zero immediately; target=14 after release.
6. SOFT_START_EN undefined, enable=1:
   - pwm_ref jumps 0 -> 14 at the 4th wrap; state goes 1 -> 3, never 2.
